stream_packet_upsizer: RTL

Stream width converter that packs SCALE consecutive DW_IN-bit input beats into one DW_IN*SCALE-bit output beat, with packet support. The input carries an end-of-packet marker, and a packet may end mid-word. In that case the partial word is flushed immediately, zero-padded, with a per-lane keep mask. The block sits between a narrow producer (e.g. a stream_writer-style source or a DMA front end) and a wide consumer. It uses the same valid/ready stream handshake on both sides. It adds packet awareness, lane ordering and full-rate operation under backpressure.

---
 rtl/stream_packet_upsizer_pkg.sv | 12 +
 rtl/stream_packet_upsizer.sv | 96 +++++++++
 2 files changed

// File: rtl/stream_packet_upsizer_pkg.sv
// Shared stream helpers for width converters.
// The lane mapping lives here so a matching downsizer can use the same ordering.
package stream_packet_upsizer_pkg;

    // Map a beat position within a word to its lane.
    // Little-endian puts the first beat in lane 0.
    // Big-endian puts the first beat in the top lane.
    function automatic int lane_index(input int cnt, input int scale, input bit big_endian);
        return big_endian ? (scale - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/stream_packet_upsizer.sv
// Packs SCALE narrow beats into one wide word, with packet support.
// A packet that ends mid-word is flushed at once. The flushed word has zero
// padding in the unused lanes and a per-lane keep mask.
//
// Handshake, both sides: a beat or word transfers on a rising edge where
// valid & ready. Valid never waits on ready. While a word is held, its
// payload stays stable. s_ready_o is combinational from m_ready_i, so a word
// can be consumed and the next beat accepted in the same cycle.
module stream_packet_upsizer
    import stream_packet_upsizer_pkg::*;
#(
    parameter int DW_IN      = 16,
    parameter int SCALE      = 3,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW_IN-1:0]         s_data_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic                     s_last_i,
    output logic [DW_IN*SCALE-1:0]   m_data_o,
    output logic [SCALE-1:0]         m_keep_o,
    output logic                     m_last_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i
);

    localparam int DW_OUT = DW_IN * SCALE;
    localparam int CW     = $clog2(SCALE);

    logic [CW-1:0]     cnt;
    logic [DW_OUT-1:0] data_q;
    logic [SCALE-1:0]  keep_q;
    logic              last_q;
    logic              valid_q;

    logic              accept;
    logic              word_done;
    int                lane;
    logic [DW_OUT-1:0] data_n;
    logic [SCALE-1:0]  keep_n;

    assign s_ready_o = !valid_q || m_ready_i;
    assign accept    = s_valid_i && s_ready_o;
    assign word_done = accept && ((cnt == CW'(SCALE - 1)) || s_last_i);

    assign m_data_o  = data_q;
    assign m_keep_o  = keep_q;
    assign m_last_o  = last_q;
    assign m_valid_o = valid_q;

    // Merge the incoming beat into its lane.
    // The first beat of a word starts from a cleared word, so lanes that a
    // short packet never writes read as zero.
    always_comb begin
        lane   = lane_index(int'(cnt), SCALE, BIG_ENDIAN != 0);
        data_n = (cnt == '0) ? '0 : data_q;
        keep_n = (cnt == '0) ? '0 : keep_q;
        for (int i = 0; i < SCALE; i++) begin
            if (i == lane) begin
                data_n[i*DW_IN +: DW_IN] = s_data_i;
                keep_n[i]                = 1'b1;
            end
        end
    end

    // Word assembly, lane counter and output valid.
    // A completing beat in the same cycle as a handoff keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= data_n;
                keep_q <= keep_n;
                if (word_done) begin
                    cnt    <= '0;
                    last_q <= s_last_i;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (word_done) begin
                valid_q <= 1'b1;
            end else if (m_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule
